// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// The optional starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [3:0] BE_ALL = 4'hF;

    // Width of a counter that must be able to hold the value max_val.
    function automatic int streak_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch (I) and load/store (D).
// With ARB_STARVE_GUARD_EN, a full D streak hands the tie to I.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_W        = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] streak,
    output owner_t           winner
);

`ifdef ARB_STARVE_GUARD_EN
    always_comb begin
        winner = d_req ? OWN_D : OWN_I;
        if (i_req && d_req && (streak == CNT_W'(MAX_D_STREAK))) begin
            winner = OWN_I;
        end
    end
`else
    // Strict D priority: the streak and i_req carry no information here.
    logic unused_pick;
    assign unused_pick = &{1'b0, i_req, streak};

    always_comb begin
        winner = d_req ? OWN_D : OWN_I;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-transaction arbiter sharing one req/gnt memory between the I and D ports.
// Define ARB_STARVE_GUARD_EN to bound consecutive contended D grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_be,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              busy
);

    localparam int CNT_W = streak_width(MAX_D_STREAK);

    arb_state_t        state_reg, state_next;
    owner_t            owner_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [3:0]        be_reg;

    owner_t            winner;
    logic [CNT_W-1:0]  streak_cnt;
    logic              grant;
    logic              rsp_take;

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK),
        .CNT_W        (CNT_W)
    ) u_pick (
        .i_req  (i_req),
        .d_req  (d_req),
        .streak (streak_cnt),
        .winner (winner)
    );

    // Grants are combinational so the requester sees acceptance in its request cycle.
    assign grant    = (state_reg == ST_IDLE) && (i_req || d_req) && !reset;
    assign i_gnt    = grant && (winner == OWN_I);
    assign d_gnt    = grant && (winner == OWN_D);
    assign rsp_take = (state_reg == ST_WAIT) && m_rvalid;

    assign m_req   = (state_reg == ST_ISSUE);
    assign m_we    = we_reg;
    assign m_addr  = addr_reg;
    assign m_wdata = wdata_reg;
    assign m_be    = be_reg;
    assign busy    = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_gnt) begin
                    state_next = we_reg ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_rvalid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_I;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                owner_reg <= winner;
                if (winner == OWN_D) begin
                    we_reg    <= d_we;
                    addr_reg  <= d_addr;
                    wdata_reg <= d_wdata;
                    be_reg    <= d_be;
                end else begin
                    we_reg    <= 1'b0;
                    addr_reg  <= i_addr;
                    wdata_reg <= '0;
                    be_reg    <= BE_ALL;
                end
            end
        end
    end

    // Per-port response registers: index 0 serves I, index 1 serves D.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic [DATA_W-1:0] rdata_reg;
            logic              rvalid_reg;
            owner_t            port_id;

            assign port_id = (gi == 1) ? OWN_D : OWN_I;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= 1'b0;
                    if (rsp_take && (owner_reg == port_id)) begin
                        rdata_reg  <= m_rdata;
                        rvalid_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign i_rdata  = g_resp[0].rdata_reg;
    assign i_rvalid = g_resp[0].rvalid_reg;
    assign d_rdata  = g_resp[1].rdata_reg;
    assign d_rvalid = g_resp[1].rvalid_reg;

`ifdef ARB_STARVE_GUARD_EN
    // Counts D wins that happened while I was also waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_cnt <= '0;
        end else if (d_gnt && i_req) begin
            streak_cnt <= streak_cnt + CNT_W'(1);
        end else if (grant) begin
            streak_cnt <= '0;
        end
    end
`else
    assign streak_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural req/gnt memory.
// Build with ARB_STARVE_GUARD_EN defined to exercise the guarded grant order.
module tb_mem_arbiter;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 32;
    localparam int MAX_D_STREAK = 4;

    logic              clk;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_be;
    logic              m_gnt;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;
    logic              busy;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        bit          port_d;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_D_STREAK (MAX_D_STREAK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural memory: m_gnt after gnt_wait stalled cycles, m_rvalid lat cycles after m_gnt.
    logic [31:0] mem [0:4095];
    bit          auto_mem = 1'b1;
    int          gnt_wait = 0;
    int          lat      = 1;
    int          waited   = 0;
    int          rv_cnt   = 0;
    logic        a_gnt    = 1'b0;
    logic        a_rvalid = 1'b0;
    logic [31:0] a_rdata  = '0;
    logic        man_gnt    = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata  = '0;

    assign m_gnt    = auto_mem ? a_gnt    : man_gnt;
    assign m_rvalid = auto_mem ? a_rvalid : man_rvalid;
    assign m_rdata  = auto_mem ? a_rdata  : man_rdata;

    always @(negedge clk) begin
        a_gnt    = 1'b0;
        a_rvalid = 1'b0;
        if (reset || !auto_mem) begin
            rv_cnt = 0;
            waited = 0;
        end else begin
            if (rv_cnt > 0) begin
                rv_cnt = rv_cnt - 1;
                if (rv_cnt == 0) a_rvalid = 1'b1;
            end
            if (m_req) begin
                if (waited >= gnt_wait) begin
                    a_gnt  = 1'b1;
                    waited = 0;
                    if (m_we) begin
                        for (int b = 0; b < 4; b++)
                            if (m_be[b]) mem[m_addr][b*8 +: 8] = m_wdata[b*8 +: 8];
                    end else begin
                        a_rdata = mem[m_addr];
                        rv_cnt  = lat;
                    end
                end else begin
                    waited = waited + 1;
                end
            end else begin
                waited = 0;
            end
        end
    end

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (!busy && !i_rvalid && !d_rvalid) break;
        end
        if (k == 50) begin
            miscompares++;
            $display("FAIL %s_idle_timeout: busy=%b required 0 within 50 cycles", nm, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        i_req = 1'b1; i_addr = 12'h0BB;
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h0AA; d_wdata = 32'h0000_1111; d_be = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busy} !== 7'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl[%0d]: gnt/rvalid/m_req/m_we/busy=%b required 0000000", c,
                         {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busy});
            end
        end
        vectors++;
        if ({i_rdata, d_rdata, m_addr, m_wdata, m_be} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: i_rdata=%h d_rdata=%h m_addr=%h m_wdata=%h m_be=%h required all 0",
                     i_rdata, d_rdata, m_addr, m_wdata, m_be);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if ({d_gnt, i_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_first_gnt: d_gnt,i_gnt=%b required 10", {d_gnt, i_gnt});
        end
        @(negedge clk);
        d_req = 1'b0;
        i_req = 1'b0;
        wait_idle("reset");
        $display("reset: done");
    endtask

    task automatic test_i_read;
        int cyc;
        bit seen_d;
        exp_t e;
        gnt_wait = 0;
        lat      = 2;
        @(negedge clk);
        i_req = 1'b1; i_addr = 12'h010;
        #1;
        vectors++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL iread_gnt: i_gnt,d_gnt=%b required 10", {i_gnt, d_gnt});
        end
        sb.push_back('{1'b0, 32'hDEADBEEF});
        @(negedge clk);
        i_req = 1'b0;
        #1;
        vectors++;
        if ({m_req, m_we, m_addr, m_be} !== {1'b1, 1'b0, 12'h010, 4'hF}) begin
            miscompares++;
            $display("FAIL iread_mreq: m_req=%b m_we=%b m_addr=%h m_be=%h required 1 0 010 f",
                     m_req, m_we, m_addr, m_be);
        end
        cyc = 1;
        seen_d = 1'b0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            #1;
            if (d_rvalid) seen_d = 1'b1;
            if (i_rvalid) break;
        end
        vectors++;
        if (cyc != 4 || seen_d) begin
            miscompares++;
            $display("FAIL iread_latency: i_rvalid at cycle %0d d_rvalid_seen=%b required cycle 4 and 0",
                     cyc, seen_d);
        end
        if (i_rvalid && sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (e.port_d || i_rdata !== e.data) begin
                miscompares++;
                $display("FAIL iread_data: i_rdata=%h required %h", i_rdata, e.data);
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (i_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL iread_pulse: i_rvalid=%b required 0 one cycle later", i_rvalid);
        end
        sb.delete();
        $display("i_read: addr=010 rdata=%h", i_rdata);
    endtask

    task automatic test_d_write_priority;
        int k;
        bit seen_d;
        exp_t e;
        gnt_wait = 0;
        lat      = 1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h020; d_wdata = 32'h1234_5678; d_be = 4'hF;
        i_req = 1'b1; i_addr = 12'h030;
        #1;
        vectors++;
        if ({d_gnt, i_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL dwr_tie: d_gnt,i_gnt=%b required 10", {d_gnt, i_gnt});
        end
        @(negedge clk);
        d_req = 1'b0;
        #1;
        vectors++;
        if ({m_req, m_we, m_addr, m_wdata, m_be, i_gnt} !== {1'b1, 1'b1, 12'h020, 32'h1234_5678, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL dwr_mreq: m_req=%b m_we=%b m_addr=%h m_wdata=%h m_be=%h i_gnt=%b required 1 1 020 12345678 f 0",
                     m_req, m_we, m_addr, m_wdata, m_be, i_gnt);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({i_gnt, d_rvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL dwr_next_gnt: i_gnt,d_rvalid=%b required 10", {i_gnt, d_rvalid});
        end
        sb.push_back('{1'b0, 32'hA5A5_0001});
        @(negedge clk);
        i_req = 1'b0;
        seen_d = 1'b0;
        for (k = 0; k < 20; k++) begin
            #1;
            if (d_rvalid) seen_d = 1'b1;
            if (i_rvalid) break;
            @(negedge clk);
        end
        vectors++;
        if (k == 20 || seen_d || sb.size() == 0) begin
            miscompares++;
            $display("FAIL dwr_iresp: i_rvalid seen=%b d_rvalid seen=%b required 1 and 0", k != 20, seen_d);
        end else begin
            e = sb.pop_front();
            if (e.port_d || i_rdata !== e.data) begin
                miscompares++;
                $display("FAIL dwr_iresp: i_rdata=%h required %h", i_rdata, e.data);
            end
        end
        vectors++;
        if (mem[12'h020] !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL dwr_mem: mem[020]=%h required 12345678", mem[12'h020]);
        end
        // Read back through the D port; I's rdata must hold its previous value.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
        #1;
        sb.push_back('{1'b1, 32'h1234_5678});
        @(negedge clk);
        d_req = 1'b0;
        for (k = 0; k < 20; k++) begin
            #1;
            if (d_rvalid) break;
            @(negedge clk);
        end
        vectors++;
        if (k == 20 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL drd_resp: d_rvalid never seen, required within 20 cycles");
        end else begin
            e = sb.pop_front();
            if (!e.port_d || d_rdata !== e.data || i_rdata !== 32'hA5A5_0001) begin
                miscompares++;
                $display("FAIL drd_resp: d_rdata=%h i_rdata=%h required %h a5a50001", d_rdata, i_rdata, e.data);
            end
        end
        sb.delete();
        wait_idle("dwr");
        $display("d_write: addr=020 wdata=12345678, readback d_rdata=%h", d_rdata);
    endtask

    task automatic test_stall;
        int k;
        bit bad;
        exp_t e;
        gnt_wait = 5;
        lat      = 1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h030;
        i_req = 1'b1; i_addr = 12'h010;
        #1;
        sb.push_back('{1'b1, 32'hA5A5_0001});
        @(negedge clk);
        d_req = 1'b0;
        bad = 1'b0;
        for (k = 0; k < 5; k++) begin
            #1;
            if ({m_req, m_we, m_addr, m_be, busy, i_gnt, d_gnt} !== {1'b1, 1'b0, 12'h030, 4'hF, 1'b1, 1'b0, 1'b0}) begin
                bad = 1'b1;
                $display("FAIL stall_hold[%0d]: m_req=%b m_we=%b m_addr=%h m_be=%h busy=%b i_gnt=%b d_gnt=%b required 1 0 030 f 1 0 0",
                         k, m_req, m_we, m_addr, m_be, busy, i_gnt, d_gnt);
            end
            @(negedge clk);
        end
        vectors++;
        if (bad) miscompares++;
        gnt_wait = 0;
        // The D response pulse and the waiting I grant land in the same cycle.
        for (k = 0; k < 20; k++) begin
            #1;
            if (d_rvalid || i_gnt) break;
            @(negedge clk);
        end
        vectors++;
        if (k == 20 || {d_rvalid, i_gnt} !== 2'b11 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL stall_resp: d_rvalid,i_gnt=%b required 11", {d_rvalid, i_gnt});
        end else begin
            e = sb.pop_front();
            if (!e.port_d || d_rdata !== e.data) begin
                miscompares++;
                $display("FAIL stall_resp: d_rdata=%h required %h", d_rdata, e.data);
            end
        end
        sb.push_back('{1'b0, 32'hDEADBEEF});
        @(negedge clk);
        i_req = 1'b0;
        for (k = 0; k < 20; k++) begin
            #1;
            if (i_rvalid) break;
            @(negedge clk);
        end
        vectors++;
        if (k == 20 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL stall_iresp: i_rvalid never seen, required within 20 cycles");
        end else begin
            e = sb.pop_front();
            if (e.port_d || i_rdata !== e.data) begin
                miscompares++;
                $display("FAIL stall_iresp: i_rdata=%h required %h", i_rdata, e.data);
            end
        end
        sb.delete();
        wait_idle("stall");
        $display("stall: 5-cycle m_gnt delay, d_rdata=%h i_rdata=%h", d_rdata, i_rdata);
    endtask

    task automatic test_reset_in_wait;
        bit bad;
        auto_mem   = 1'b0;
        man_gnt    = 1'b0;
        man_rvalid = 1'b0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 12'h050;
        @(negedge clk);
        i_req   = 1'b0;
        man_gnt = 1'b1;
        @(negedge clk);
        man_gnt = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstwait_busy: busy=%b required 1 in WAIT", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hCAFE_F00D;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            man_rvalid = 1'b0;
            #1;
            if ({i_rvalid, d_rvalid, busy} !== 3'b000 || i_rdata !== '0 || d_rdata !== '0) begin
                bad = 1'b1;
                $display("FAIL rstwait_stale[%0d]: i_rvalid=%b d_rvalid=%b busy=%b i_rdata=%h d_rdata=%h required 0 0 0 0 0",
                         c, i_rvalid, d_rvalid, busy, i_rdata, d_rdata);
            end
        end
        vectors++;
        if (bad) miscompares++;
        auto_mem = 1'b1;
        $display("reset_in_wait: stale m_rvalid cafef00d ignored");
    endtask

    task automatic test_streak;
        int  grants;
        int  cyc;
        bit  got_d;
        bit  want_d;
        string order;
        gnt_wait = 0;
        lat      = 1;
        grants   = 0;
        order    = "";
        @(negedge clk);
        i_req = 1'b1; i_addr = 12'h010;
        d_req = 1'b1; d_we = 1'b1; d_addr = 12'h100; d_wdata = 32'h0000_0042; d_be = 4'hF;
        for (cyc = 0; cyc < 300 && grants < 10; cyc++) begin
            #1;
            if (i_gnt || d_gnt) begin
                got_d = d_gnt;
`ifdef ARB_STARVE_GUARD_EN
                want_d = ((grants % (MAX_D_STREAK + 1)) != MAX_D_STREAK);
`else
                want_d = 1'b1;
`endif
                vectors++;
                if (got_d !== want_d || (i_gnt && d_gnt)) begin
                    miscompares++;
                    $display("FAIL streak_grant[%0d]: got %s required %s", grants,
                             got_d ? "D" : "I", want_d ? "D" : "I");
                end
                order = {order, got_d ? "D" : "I"};
                grants++;
            end
            @(negedge clk);
        end
        vectors++;
        if (grants != 10) begin
            miscompares++;
            $display("FAIL streak_timeout: %0d grants seen, required 10", grants);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        wait_idle("streak");
        $display("streak: grant order %s", order);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
        mem[12'h010] = 32'hDEADBEEF;
        mem[12'h030] = 32'hA5A5_0001;
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

        test_reset();
        test_i_read();
        test_d_write_priority();
        test_stall();
        test_reset_in_wait();
        test_streak();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
